// File: rtl/complex_mult_pipe_pkg.sv
// Shared constants and helpers for the pipelined complex multiplier.
// Provides FULL_WIDTH, parameter checks and the round/saturate arithmetic.
package complex_mult_pipe_pkg;

    // Wide enough for any supported FULL_WIDTH+1 intermediate.
    localparam int WIDE = 128;

    typedef logic signed [WIDE-1:0] wide_t;

    function automatic int full_width(
        input int aw,
        input int bw
    );
        return aw + bw + 2;
    endfunction

    function automatic bit cfg_ok(
        input int shift,
        input int rnd,
        input int fw,
        input int ow
    );
        return (shift >= 0)
            && (shift <= fw - 1)
            && ((rnd == 0) || (shift >= 1))
            && (fw + 1 < WIDE)
            && (ow >= 2)
            && (ow < WIDE);
    endfunction

    // (p + bias) >>> shift; the wide type keeps the bias add exact.
    function automatic wide_t round_shift(
        input wide_t p,
        input int    shift,
        input bit    rnd
    );
        wide_t bias;
        bias = '0;
        if (rnd && (shift > 0)) begin
            bias = wide_t'(1) <<< (shift - 1);
        end
        return (p + bias) >>> shift;
    endfunction

    // {above max, below min} for an ow-bit signed result.
    function automatic logic [1:0] sat_dir(
        input wide_t r,
        input int    ow
    );
        wide_t hi_lim;
        wide_t lo_lim;
        hi_lim = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        lo_lim = -hi_lim - wide_t'(1);
        return {r > hi_lim, r < lo_lim};
    endfunction

endpackage

// File: rtl/complex_mult_pipe_round_sat.sv
// One lane of the output stage: round, arithmetic shift, saturate.
// Ports: din (IN_WIDTH signed), dout (OUT_WIDTH signed), sat flag.
module round_sat
    import complex_mult_pipe_pkg::*;
#(
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int ROUND     = 1
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    localparam logic signed [OUT_WIDTH-1:0] MAXV =
        {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MINV =
        {1'b1, {(OUT_WIDTH-1){1'b0}}};

    wide_t r;
    logic  hi;
    logic  lo;

    always_comb begin
        r = round_shift(wide_t'(din), SHIFT, ROUND != 0);
        {hi, lo} = sat_dir(r, OUT_WIDTH);
        sat = hi | lo;
        unique case (1'b1)
            hi:      dout = MAXV;
            lo:      dout = MINV;
            default: dout = r[OUT_WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/complex_mult_pipe.sv
// 4-stage complex multiplier: out = a*b or a*conj(b), scaled, saturated.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, conj_b,
// dina_i/q, dinb_i/q in; out_valid/out_ready, dout_i/q, out_sat out.
module complex_mult_pipe
    import complex_mult_pipe_pkg::*;
#(
    parameter int DINA_WIDTH = 16,
    parameter int DINB_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int SHIFT      = 15,
    parameter int ROUND      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         conj_b,
    input  logic signed [DINA_WIDTH-1:0] dina_i,
    input  logic signed [DINA_WIDTH-1:0] dina_q,
    input  logic signed [DINB_WIDTH-1:0] dinb_i,
    input  logic signed [DINB_WIDTH-1:0] dinb_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout_i,
    output logic signed [DOUT_WIDTH-1:0] dout_q,
    output logic                         out_sat
);

    localparam int AW = DINA_WIDTH;
    localparam int BW = DINB_WIDTH;
    localparam int FW = full_width(AW, BW);

    if (!cfg_ok(SHIFT, ROUND, FW, DOUT_WIDTH)) begin : g_cfg_err
        $error("complex_mult_pipe: illegal SHIFT/ROUND/width");
    end

    // Whole pipeline advances as one; a stalled output freezes all.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // b'_q at BW+1 bits so negating the most negative value is exact.
    logic signed [BW:0] bq_c;
    always_comb begin
        bq_c = (BW+1)'(dinb_q);
        if (conj_b) begin
            bq_c = -(BW+1)'(dinb_q);
        end
    end

    // S1: operands plus pre-adders for the 3-multiplier form
    //   k1 = br*(ar+ai), k2 = ar*(bq-br), k3 = ai*(br+bq)
    logic                 s1_v;
    logic signed [AW-1:0] s1_ar;
    logic signed [AW-1:0] s1_ai;
    logic signed [BW-1:0] s1_br;
    logic signed [AW:0]   s1_sa;
    logic signed [BW+1:0] s1_db;
    logic signed [BW+1:0] s1_sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
        end else if (en) begin
            s1_v  <= in_valid;
            s1_ar <= dina_i;
            s1_ai <= dina_q;
            s1_br <= dinb_i;
            s1_sa <= (AW+1)'(dina_i) + (AW+1)'(dina_q);
            s1_db <= (BW+2)'(bq_c) - (BW+2)'(dinb_i);
            s1_sb <= (BW+2)'(dinb_i) + (BW+2)'(bq_c);
        end
    end

    // S2: three products at full width
    logic                 s2_v;
    logic signed [FW-1:0] s2_k1;
    logic signed [FW-1:0] s2_k2;
    logic signed [FW-1:0] s2_k3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else if (en) begin
            s2_v  <= s1_v;
            s2_k1 <= FW'(s1_br) * FW'(s1_sa);
            s2_k2 <= FW'(s1_ar) * FW'(s1_db);
            s2_k3 <= FW'(s1_ai) * FW'(s1_sb);
        end
    end

    // S3: post-adders; wrap-around in k terms cancels exactly here
    logic                 s3_v;
    logic signed [FW-1:0] s3_pi;
    logic signed [FW-1:0] s3_pq;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v <= 1'b0;
        end else if (en) begin
            s3_v  <= s2_v;
            s3_pi <= s2_k1 - s2_k3;
            s3_pq <= s2_k1 + s2_k2;
        end
    end

    // S4: round, shift, saturate per lane, then register outputs
    logic signed [DOUT_WIDTH-1:0] rs_i;
    logic signed [DOUT_WIDTH-1:0] rs_q;
    logic                         sat_i;
    logic                         sat_q;

    round_sat #(
        .IN_WIDTH (FW),
        .OUT_WIDTH(DOUT_WIDTH),
        .SHIFT    (SHIFT),
        .ROUND    (ROUND)
    ) u_rs_i (
        .din (s3_pi),
        .dout(rs_i),
        .sat (sat_i)
    );

    round_sat #(
        .IN_WIDTH (FW),
        .OUT_WIDTH(DOUT_WIDTH),
        .SHIFT    (SHIFT),
        .ROUND    (ROUND)
    ) u_rs_q (
        .din (s3_pq),
        .dout(rs_q),
        .sat (sat_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout_i    <= '0;
            dout_q    <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s3_v;
            dout_i    <= rs_i;
            dout_q    <= rs_q;
            out_sat   <= sat_i | sat_q;
        end
    end

endmodule
